// File: rtl/display_pkg.sv
// Shared definitions for the result display: converter FSM states,
// active-low segment codes {g,f,e,d,c,b,a} and the decimal range helper.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Index 9 is listed first so that SEG_DIGITS[d] yields the code for digit d.
  localparam logic [9:0][6:0] SEG_DIGITS = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

endpackage

// File: rtl/result_display_if.sv
// Calculator result in, multiplexed 7-segment display and conversion status out.
// The display block takes the slave side; the result producer takes the master side.
interface result_display_if #(
  parameter int WORD_LENGTH = 4,
  parameter int DIGITS      = 3
);
  logic [WORD_LENGTH-1:0] C;
  logic                   Carry;
  logic [6:0]             seg;
  logic [DIGITS-1:0]      an;
  logic [4*DIGITS-1:0]    bcd;
  logic                   busy;
  logic                   overflow;

  modport master (
    output C, Carry,
    input  seg, an, bcd, busy, overflow
  );

  modport slave (
    input  C, Carry,
    output seg, an, bcd, busy, overflow
  );
endinterface

// File: rtl/bin_to_bcd.sv
// Sequential shift-add-3 binary to BCD converter that re-converts whenever the input
// differs from the value on display; result valid WORD_LENGTH+3 cycles after the change.
module bin_to_bcd
  import display_pkg::*;
#(
  parameter int WORD_LENGTH = 4,
  parameter int DIGITS      = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_LENGTH:0]  value_i,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  busy_o,
  output logic                  overflow_o
);
  localparam int N  = WORD_LENGTH + 1;
  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(N + 1);
  localparam int unsigned LIMIT = pow10(DIGITS);

  state_e        state_q;
  logic [N-1:0]  val_q, shown_q, sr_q, sr_d;
  logic [BW-1:0] acc_q, acc_adj, acc_d, bcd_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q, overflow_q;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    {acc_d, sr_d} = {acc_adj, sr_q} << 1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      val_q      <= '0;
      shown_q    <= '0;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (value_i != shown_q) begin
            val_q   <= value_i;
            sr_q    <= value_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          acc_q <= acc_d;
          sr_q  <= sr_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(N - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          // Out-of-range values show dashes, so the truncated accumulator is never used.
          if (32'(val_q) >= LIMIT) begin
            overflow_q <= 1'b1;
            bcd_q      <= '0;
          end else begin
            overflow_q <= 1'b0;
            bcd_q      <= acc_q;
          end
          shown_q <= val_q;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bcd_o      = bcd_q;
  assign busy_o     = busy_q;
  assign overflow_o = overflow_q;
endmodule

// File: rtl/result_display.sv
// Converts {Carry, C} to BCD and scans it onto an active-low multiplexed 7-segment display
// with leading-zero blanking; seg/an are registered and lag index or bcd changes by one cycle.
module result_display
  import display_pkg::*;
#(
  parameter int WORD_LENGTH = 4,
  parameter int DIGITS      = 3,
  parameter int REFRESH_DIV = 50000
) (
  input  logic            clk,
  input  logic            reset,
  result_display_if.slave bus
);
  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = 4 * DIGITS;

  logic [PW-1:0]     pre_q;
  logic [IW-1:0]     idx_q;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [BW-1:0]     bcd_w, digits_sh;
  logic              busy_w, ovf_w;

  bin_to_bcd #(
    .WORD_LENGTH(WORD_LENGTH),
    .DIGITS     (DIGITS)
  ) u_conv (
    .clk       (clk),
    .reset     (reset),
    .value_i   ({bus.Carry, bus.C}),
    .bcd_o     (bcd_w),
    .busy_o    (busy_w),
    .overflow_o(ovf_w)
  );

  // Shifting the selected digit to the bottom leaves zero exactly when it and all higher digits are zero.
  always_comb begin
    digits_sh = bcd_w >> {idx_q, 2'b00};
    an_d      = ~(DIGITS'(1) << idx_q);
    if (ovf_w)                                   seg_d = SEG_DASH;
    else if (idx_q != '0 && digits_sh == '0)     seg_d = SEG_BLANK;
    else if (digits_sh[3:0] > 4'd9)              seg_d = SEG_DASH;
    else                                         seg_d = SEG_DIGITS[digits_sh[3:0]];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_q <= '0;
      idx_q <= '0;
      seg_q <= SEG_BLANK;
      an_q  <= '1;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
      if (pre_q == PW'(REFRESH_DIV - 1)) begin
        pre_q <= '0;
        idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
      end else begin
        pre_q <= pre_q + 1'b1;
      end
    end
  end

  assign bus.seg      = seg_q;
  assign bus.an       = an_q;
  assign bus.bcd      = bcd_w;
  assign bus.busy     = busy_w;
  assign bus.overflow = ovf_w;
endmodule

// File: tb/tb_result_display.sv
// Bench for result_display: two instances (3 digits and 1 digit) checked every cycle
// against a decimal-arithmetic model, plus hand-computed expectations for key scenarios.
module tb_result_display;
  localparam int WL = 4;
  localparam int N  = WL + 1;
  localparam int RD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  bit   cmp_en = 1'b0;
  always #5 clk = ~clk;

  result_display_if #(.WORD_LENGTH(WL), .DIGITS(3)) bus_a ();
  result_display_if #(.WORD_LENGTH(WL), .DIGITS(1)) bus_b ();

  result_display #(.WORD_LENGTH(WL), .DIGITS(3), .REFRESH_DIV(RD)) u_a (
    .clk(clk), .reset(reset), .bus(bus_a));
  result_display #(.WORD_LENGTH(WL), .DIGITS(1), .REFRESH_DIV(RD)) u_b (
    .clk(clk), .reset(reset), .bus(bus_b));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks the displayed integer, not BCD bits.
  int DG [2] = '{3, 1};
  logic [6:0] SEGT [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  int m_cnt [2], m_lat [2], m_shown [2], m_val [2], m_pre [2], m_idx [2], m_seg [2], m_an [2];
  bit m_ovf [2];

  function automatic int p10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic int to_bcd(input int v, input int d);
    int r = 0;
    for (int i = 0; i < d; i++) r = r | (((v / p10(i)) % 10) << (4 * i));
    return r;
  endfunction

  function automatic int seg_for(input int k, input int idx);
    if (m_ovf[k]) return 'b0111111;
    if (idx > 0 && m_val[k] < p10(idx)) return 'h7F;
    return int'(SEGT[(m_val[k] / p10(idx)) % 10]);
  endfunction

  task automatic model_step(input int k, input int inval, input bit rst);
    int d = DG[k];
    if (rst) begin
      m_cnt[k] = 0; m_lat[k] = 0; m_shown[k] = 0; m_val[k] = 0; m_ovf[k] = 0;
      m_pre[k] = 0; m_idx[k] = 0; m_seg[k] = 'h7F; m_an[k] = (1 << d) - 1;
    end else begin
      m_seg[k] = seg_for(k, m_idx[k]);
      m_an[k]  = ((1 << d) - 1) & ~(1 << m_idx[k]);
      if (m_pre[k] == RD - 1) begin
        m_pre[k] = 0;
        m_idx[k] = (m_idx[k] + 1) % d;
      end else begin
        m_pre[k]++;
      end
      if (m_cnt[k] == 0) begin
        if (inval != m_shown[k]) begin
          m_lat[k] = inval;
          m_cnt[k] = N + 1;
        end
      end else begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) begin
          m_shown[k] = m_lat[k];
          m_ovf[k]   = (m_lat[k] >= p10(d));
          m_val[k]   = m_ovf[k] ? 0 : m_lat[k];
        end
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, int'({bus_a.Carry, bus_a.C}), reset);
    model_step(1, int'({bus_b.Carry, bus_b.C}), reset);
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("a.seg",  int'(bus_a.seg),      m_seg[0]);
      check("a.an",   int'(bus_a.an),       m_an[0]);
      check("a.bcd",  int'(bus_a.bcd),      to_bcd(m_val[0], 3));
      check("a.busy", int'(bus_a.busy),     int'(m_cnt[0] > 0));
      check("a.ovf",  int'(bus_a.overflow), int'(m_ovf[0]));
      check("b.seg",  int'(bus_b.seg),      m_seg[1]);
      check("b.an",   int'(bus_b.an),       m_an[1]);
      check("b.bcd",  int'(bus_b.bcd),      to_bcd(m_val[1], 1));
      check("b.busy", int'(bus_b.busy),     int'(m_cnt[1] > 0));
      check("b.ovf",  int'(bus_b.overflow), int'(m_ovf[1]));
    end
  end

  task automatic drive_a(input int v);
    bus_a.Carry = 1'(v >> 4);
    bus_a.C     = 4'(v);
  endtask

  task automatic drive_b(input int v);
    bus_b.Carry = 1'(v >> 4);
    bus_b.C     = 4'(v);
  endtask

  logic [2:0] AN_SEQ [4] = '{3'b110, 3'b101, 3'b011, 3'b110};

  initial begin
    int nb, seen5, first9;
    int s [3];
    drive_a(0);
    drive_b(0);
    reset = 1'b1;
    @(negedge clk);
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst.an",   int'(bus_a.an),   'b111);
    check("rst.seg",  int'(bus_a.seg),  'h7F);
    check("rst.bcd",  int'(bus_a.bcd),  0);
    check("rst.busy", int'(bus_a.busy), 0);
    reset = 1'b0;
    @(negedge clk);
    check("first.an",  int'(bus_a.an),  'b110);
    check("first.seg", int'(bus_a.seg), 'b1000000);

    // 31 -> six busy cycles, then 031 with hundreds blanked.
    drive_a(31);
    nb = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      nb += int'(bus_a.busy);
    end
    check("v31.busy_cycles", nb, 6);
    check("v31.bcd", int'(bus_a.bcd), 'h031);
    @(negedge clk);
    s = '{0, 0, 0};
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus_a.an == 3'b110) s[0] = int'(bus_a.seg);
      if (bus_a.an == 3'b101) s[1] = int'(bus_a.seg);
      if (bus_a.an == 3'b011) s[2] = int'(bus_a.seg);
    end
    check("v31.seg0", s[0], 'b1111001);
    check("v31.seg1", s[1], 'b0110000);
    check("v31.seg2", s[2], 'b1111111);

    // 5 then 9 one cycle later: both conversions must be observed.
    drive_a(5);
    seen5 = 0;
    first9 = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) drive_a(9);
      if (bus_a.bcd == 12'h005) seen5 = 1;
      if (bus_a.bcd == 12'h009 && first9 == 99) first9 = i;
    end
    check("chg.seen5", seen5, 1);
    check("chg.final9", int'(bus_a.bcd), 'h009);
    check("chg.within14", int'(first9 <= 14), 1);

    // Single-digit instance: 12 overflows, 7 fits.
    drive_b(12);
    repeat (8) @(negedge clk);
    check("d1.ovf12", int'(bus_b.overflow), 1);
    check("d1.bcd12", int'(bus_b.bcd), 0);
    check("d1.seg12", int'(bus_b.seg), 'b0111111);
    drive_b(7);
    repeat (8) @(negedge clk);
    check("d1.ovf7", int'(bus_b.overflow), 0);
    check("d1.bcd7", int'(bus_b.bcd), 7);
    check("d1.seg7", int'(bus_b.seg), 'b1111000);

    // Reset on the third SHIFT cycle of converting 25, then reconvert after release.
    drive_a(25);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort.busy", int'(bus_a.busy), 0);
    check("abort.bcd",  int'(bus_a.bcd), 0);
    reset = 1'b0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      check("scan.an", int'(bus_a.an), int'(AN_SEQ[j / 4]));
      if (j == 6) check("abort.bcd25", int'(bus_a.bcd), 'h025);
    end

    // Random phase: value changes on both instances and occasional resets.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 5) == 0) drive_a(int'($urandom_range(0, 31)));
      if ($urandom_range(0, 5) == 0) drive_b(int'($urandom_range(0, 31)));
    end
    reset = 1'b0;
    repeat (20) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
